// File: rtl/module_decodificador_secded_pipe.sv
// Two-stage pipelined SECDED (extended Hamming) decoder with valid/ready flow control.
// Optional saturating error counters are built only when SECDED_CNT_EN is defined.
module module_decodificador_secded_pipe #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16,
  localparam int P_W   = (8  >= DATA_W + 4) ? 3 :
                         (16 >= DATA_W + 5) ? 4 :
                         (32 >= DATA_W + 6) ? 5 : 6,
  localparam int N_W   = DATA_W + P_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [N_W-1:0]    codeword_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] datos_corregidos,
  output logic [P_W-1:0]    sindrome,
  output logic              err_single,
  output logic              err_double,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_single,
  output logic [CNT_W-1:0]  cnt_double
);

  // Handshake: a word moves in on valid_in & ready_in and out on valid_out & ready_out;
  // a stage loads when it is empty or the stage after it is loading.

  // Codeword position of data bit idx: the idx-th non-power-of-2 position above 0.
  function automatic int data_pos(input int idx);
    int k;
    data_pos = 0;
    k = 0;
    for (int p = 1; p < N_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (k == idx) data_pos = p;
        k++;
      end
    end
  endfunction

  logic              v1, v2;
  logic              ld1, ld2;
  logic [N_W-1:0]    cw1;
  logic [P_W-1:0]    syn1;
  logic              par1;
  logic [P_W-1:0]    syn_c;
  logic              par_c;
  logic [N_W-1:0]    cw_fix;
  logic [DATA_W-1:0] data_c;
  logic              single_c, double_c;
  logic              xfer_out;

  assign ld2       = ~v2 | ready_out;
  assign ld1       = ~v1 | ld2;
  assign ready_in  = ld1;
  assign valid_out = v2;
  assign xfer_out  = v2 & ready_out;

  always_comb begin
    syn_c = '0;
    par_c = ^codeword_in;
    for (int i = 1; i < N_W; i++) begin
      if (codeword_in[i]) syn_c = syn_c ^ P_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      cw1  <= '0;
      syn1 <= '0;
      par1 <= 1'b0;
    end else if (ld1) begin
      v1   <= valid_in;
      cw1  <= codeword_in;
      syn1 <= syn_c;
      par1 <= par_c;
    end
  end

  // Odd parity with a zero syndrome means only the global parity bit flipped.
  always_comb begin
    cw_fix   = cw1;
    single_c = 1'b0;
    double_c = 1'b0;
    if (par1) begin
      if (int'(syn1) < N_W) single_c = 1'b1;
      else                  double_c = 1'b1;
      for (int i = 1; i < N_W; i++) begin
        if (syn1 == P_W'(i)) cw_fix[i] = ~cw1[i];
      end
    end else if (syn1 != '0) begin
      double_c = 1'b1;
    end
    data_c = '0;
    for (int d = 0; d < DATA_W; d++) begin
      data_c[d] = cw_fix[data_pos(d)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2               <= 1'b0;
      datos_corregidos <= '0;
      sindrome         <= '0;
      err_single       <= 1'b0;
      err_double       <= 1'b0;
    end else if (ld2) begin
      v2               <= v1;
      datos_corregidos <= data_c;
      sindrome         <= syn1;
      err_single       <= v1 & single_c;
      err_double       <= v1 & double_c;
    end
  end

`ifdef SECDED_CNT_EN
  // Counters advance only on an output transfer; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (clr_cnt) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else begin
      if (xfer_out && err_single && (cnt_single != '1)) cnt_single <= cnt_single + 1'b1;
      if (xfer_out && err_double && (cnt_double != '1)) cnt_double <= cnt_double + 1'b1;
    end
  end
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = clr_cnt | xfer_out;
  assign cnt_single = '0;
  assign cnt_double = '0;
`endif

endmodule

// File: tb/tb_module_decodificador_secded_pipe.sv
// Directed bench for the SECDED pipeline decoder (DATA_W=4, CNT_W=2).
// Counter expectations follow whether SECDED_CNT_EN is defined for the build.
module tb_module_decodificador_secded_pipe;

`ifdef SECDED_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] codeword_in;
  logic       valid_out;
  logic       ready_out;
  logic [3:0] datos_corregidos;
  logic [2:0] sindrome;
  logic       err_single;
  logic       err_double;
  logic       clr_cnt;
  logic [1:0] cnt_single;
  logic [1:0] cnt_double;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] exp_q[$];
  logic [7:0] cw_tab[8];
  logic [3:0] dat_tab[8];

  module_decodificador_secded_pipe #(.DATA_W(4), .CNT_W(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid_in(valid_in),
    .ready_in(ready_in),
    .codeword_in(codeword_in),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .datos_corregidos(datos_corregidos),
    .sindrome(sindrome),
    .err_single(err_single),
    .err_double(err_double),
    .clr_cnt(clr_cnt),
    .cnt_single(cnt_single),
    .cnt_double(cnt_double)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_cnt(input logic [1:0] v);
    exp_cnt = CNT_EN ? v : 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller sits at a negedge; returns at the negedge after the output transfer.
  task automatic send(input logic [7:0] cw, input logic [3:0] d, input logic [2:0] s,
                      input logic es, input logic ed, input logic clr, input string tag);
    valid_in    = 1'b1;
    codeword_in = cw;
    @(negedge clk);
    valid_in = 1'b0;
    chk({tag, " latency"}, valid_out, 1'b0);
    @(negedge clk);
    chk({tag, " valid"}, valid_out, 1'b1);
    chk({tag, " data"}, datos_corregidos, d);
    chk({tag, " syn"}, sindrome, s);
    chk({tag, " single"}, err_single, es);
    chk({tag, " double"}, err_double, ed);
    clr_cnt = clr;
    @(negedge clk);
    clr_cnt = 1'b0;
    chk({tag, " drained"}, valid_out, 1'b0);
  endtask

  initial begin
    int sent, got, in_pipe;
    cw_tab  = '{8'h0F, 8'h2F, 8'h0E, 8'h27, 8'hAA, 8'hEA, 8'h00, 8'h01};
    dat_tab = '{4'h1,  4'h1,  4'h1,  4'h2,  4'hB,  4'hB,  4'h0,  4'h0};
    rst_n       = 1'b0;
    valid_in    = 1'b0;
    codeword_in = '0;
    ready_out   = 1'b1;
    clr_cnt     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst valid_out", valid_out, 1'b0);
    chk("rst ready_in", ready_in, 1'b1);
    chk("rst data", datos_corregidos, 4'h0);
    chk("rst syn", sindrome, 3'd0);
    chk("rst errs", {err_single, err_double}, 2'b00);
    chk("rst cnts", {cnt_single, cnt_double}, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'h0F, 4'h1, 3'd0, 1'b0, 1'b0, 1'b0, "clean 0F");
    chk("cnt_single after clean", cnt_single, exp_cnt(2'd0));
    send(8'h2F, 4'h1, 3'd5, 1'b1, 1'b0, 1'b0, "pos5 flip");
    chk("cnt_single after pos5", cnt_single, exp_cnt(2'd1));
    send(8'h0E, 4'h1, 3'd0, 1'b1, 1'b0, 1'b0, "bit0 flip");
    chk("cnt_single after bit0", cnt_single, exp_cnt(2'd2));
    send(8'h27, 4'h2, 3'd6, 1'b0, 1'b1, 1'b0, "double 27");
    chk("cnt_double after 27", cnt_double, exp_cnt(2'd1));
    send(8'hAA, 4'hB, 3'd0, 1'b0, 1'b0, 1'b0, "clean AA");
    send(8'hEA, 4'hB, 3'd6, 1'b1, 1'b0, 1'b0, "pos6 flip");
    chk("cnt_single at max", cnt_single, exp_cnt(2'd3));

    // Eight-word stream with a three-cycle consumer stall.
    sent = 0; got = 0; in_pipe = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      ready_out   = !(c >= 4 && c <= 6);
      valid_in    = (sent < 8);
      codeword_in = (sent < 8) ? cw_tab[sent] : 8'h00;
      #1;
      chk("stream ready_in", ready_in, (in_pipe < 2) || ready_out);
      if (valid_out) begin
        if (exp_q.size() == 0) chk("stream spurious valid_out", valid_out, 1'b0);
        else chk("stream data", datos_corregidos, exp_q[0]);
      end
      if (valid_out && ready_out && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        got++;
        in_pipe--;
      end
      if (valid_in && ready_in) begin
        exp_q.push_back(dat_tab[sent]);
        sent++;
        in_pipe++;
      end
      @(negedge clk);
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    chk("stream delivered", got, 8);
    chk("cnt_single saturated", cnt_single, exp_cnt(2'd3));
    chk("cnt_double after stream", cnt_double, exp_cnt(2'd2));

    send(8'h2F, 4'h1, 3'd5, 1'b1, 1'b0, 1'b0, "sat single");
    chk("cnt_single held at max", cnt_single, exp_cnt(2'd3));
    send(8'h2F, 4'h1, 3'd5, 1'b1, 1'b0, 1'b1, "clr with error");
    chk("cnt_single cleared", cnt_single, 2'd0);
    chk("cnt_double cleared", cnt_double, 2'd0);
    send(8'h01, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, "bit0 after clr");
    chk("cnt_single after clr", cnt_single, exp_cnt(2'd1));

    // Reset with words in flight.
    valid_in    = 1'b1;
    codeword_in = 8'h0F;
    repeat (2) @(negedge clk);
    chk("pre-reset valid_out", valid_out, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid reset valid_out", valid_out, 1'b0);
    chk("mid reset ready_in", ready_in, 1'b1);
    chk("mid reset cnt_single", cnt_single, 2'd0);
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post reset idle", valid_out, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
